// File: rtl/leaf_bft_depacketizer.sv
// Input-side stage for a leaf operator: filters BFT packets addressed to this leaf,
// demultiplexes payloads into per-port FWFT FIFOs and counts drops/misroutes.
module leaf_bft_depacketizer #(
  parameter int          NUM_PORTS  = 2,
  parameter logic [4:0]  LEAF_ADDR  = 5'd0,
  parameter int          FIFO_DEPTH = 16,
  parameter int          PAYLOAD_W  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ap_start,
  input  logic [48:0]                    din_leaf_bft2interface,
  output logic [NUM_PORTS*PAYLOAD_W-1:0] dout_data,
  output logic [NUM_PORTS-1:0]           dout_valid,
  input  logic [NUM_PORTS-1:0]           dout_ready,
  output logic                           resend_req,
  output logic [15:0]                    drop_cnt,
  output logic [15:0]                    misroute_cnt
);

  localparam int         AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C    = FIFO_DEPTH[AW:0];
  localparam logic [4:0] NUM_PORTS_C = NUM_PORTS[4:0];

  logic                 pkt_valid;
  logic [4:0]           pkt_addr;
  logic [3:0]           pkt_port;
  logic [PAYLOAD_W-1:0] pkt_payload;
  logic                 pkt_hit;
  logic                 pkt_misroute;
  logic [NUM_PORTS-1:0] push_rej;
  logic                 any_drop;

  // Reserved header bits carry nothing for this leaf.
  logic unused_reserved;
  assign unused_reserved = ^din_leaf_bft2interface[38:32];

  // Stage 1: the valid bit is gated by ap_start in the cycle the packet arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_valid   <= 1'b0;
      pkt_addr    <= '0;
      pkt_port    <= '0;
      pkt_payload <= '0;
    end else begin
      pkt_valid   <= din_leaf_bft2interface[48] & ap_start;
      pkt_addr    <= din_leaf_bft2interface[47:43];
      pkt_port    <= din_leaf_bft2interface[42:39];
      pkt_payload <= din_leaf_bft2interface[PAYLOAD_W-1:0];
    end
  end

  assign pkt_hit      = pkt_valid && (pkt_addr == LEAF_ADDR) &&
                        ({1'b0, pkt_port} < NUM_PORTS_C);
  assign pkt_misroute = pkt_valid && !pkt_hit;
  assign any_drop     = |push_rej;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [PAYLOAD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 pop;
    logic                 push_req;
    logic                 push_ok;

    assign pop      = (count != '0) && dout_ready[p];
    assign push_req = pkt_hit && (pkt_port == 4'(p));
    // A full FIFO still takes the packet when it frees a slot on the same edge.
    assign push_ok  = push_req && ((count < DEPTH_C) || pop);
    assign push_rej[p] = push_req && !push_ok;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= pkt_payload;
    end

    // Data is masked while empty so the bus reads zero after reset.
    assign dout_valid[p] = (count != '0);
    assign dout_data[p*PAYLOAD_W +: PAYLOAD_W] = dout_valid[p] ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resend_req   <= 1'b0;
      drop_cnt     <= '0;
      misroute_cnt <= '0;
    end else begin
      resend_req <= any_drop;
      if (any_drop && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
      if (pkt_misroute && (misroute_cnt != 16'hFFFF))
        misroute_cnt <= misroute_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_leaf_bft_depacketizer.sv
// Scoreboard bench for leaf_bft_depacketizer: stimulus pushes expected payloads,
// a negedge monitor pops and compares every delivered word.
module tb_leaf_bft_depacketizer;

  logic        clk;
  logic        reset;
  logic        ap_start;
  logic [48:0] din;
  logic [63:0] dout_data;
  logic [1:0]  dout_valid;
  logic [1:0]  dout_ready;
  logic        resend_req;
  logic [15:0] drop_cnt;
  logic [15:0] misroute_cnt;

  int compared   = 0;
  int mismatched = 0;
  int resend_seen = 0;
  int rx_cnt1 = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  leaf_bft_depacketizer #(
    .NUM_PORTS(2), .LEAF_ADDR(5'd3), .FIFO_DEPTH(16), .PAYLOAD_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ap_start(ap_start),
    .din_leaf_bft2interface(din),
    .dout_data(dout_data),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .resend_req(resend_req),
    .drop_cnt(drop_cnt),
    .misroute_cnt(misroute_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one packet for one cycle; caller starts just after a rising edge.
  task automatic applyStimulus(input logic [4:0] addr, input logic [3:0] port,
                               input logic [31:0] payload, input bit expect_acc);
    din = {1'b1, addr, port, 7'h00, payload};
    if (expect_acc) begin
      if (port == 4'd0) exp_q0.push_back(payload);
      else              exp_q1.push_back(payload);
    end
    @(posedge clk); #1;
    din = '0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a word is consumed whenever valid and ready meet.
  always @(negedge clk) begin
    if (reset) begin
      if (resend_req) resend_seen++;
      if (dout_valid[0] && dout_ready[0]) begin
        if (exp_q0.size() == 0) checkOutput("unexpected_p0", {32'h0, dout_data[31:0]}, 64'hFFFF_FFFF_FFFF_FFFF);
        else checkOutput("data_p0", {32'h0, dout_data[31:0]}, {32'h0, exp_q0.pop_front()});
      end
      if (dout_valid[1] && dout_ready[1]) begin
        rx_cnt1++;
        if (exp_q1.size() == 0) checkOutput("unexpected_p1", {32'h0, dout_data[63:32]}, 64'hFFFF_FFFF_FFFF_FFFF);
        else checkOutput("data_p1", {32'h0, dout_data[63:32]}, {32'h0, exp_q1.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b0;
    ap_start = 1'b0;
    din = '0;
    dout_ready = 2'b11;
    waitCycles(3);
    checkOutput("rst_valid", {62'h0, dout_valid}, 64'h0);
    checkOutput("rst_data", dout_data, 64'h0);
    checkOutput("rst_drop", {48'h0, drop_cnt}, 64'h0);
    checkOutput("rst_misroute", {48'h0, misroute_cnt}, 64'h0);
    checkOutput("rst_resend", {63'h0, resend_req}, 64'h0);
    reset = 1'b1;
    waitCycles(2);

    $display("[TB] basic routing");
    ap_start = 1'b1;
    applyStimulus(5'd3, 4'd1, 32'hDEADBEEF, 1'b1);
    checkOutput("lat_early", {62'h0, dout_valid}, 64'h0);
    waitCycles(1);
    checkOutput("lat_valid", {62'h0, dout_valid}, 64'h2);
    checkOutput("lat_data", {32'h0, dout_data[63:32]}, 64'hDEADBEEF);
    waitCycles(1);
    checkOutput("one_cycle", {62'h0, dout_valid}, 64'h0);

    $display("[TB] misroute");
    applyStimulus(5'd5, 4'd0, 32'h11111111, 1'b0);
    applyStimulus(5'd3, 4'd7, 32'h22222222, 1'b0);
    waitCycles(3);
    checkOutput("misroute_cnt", {48'h0, misroute_cnt}, 64'd2);
    checkOutput("misroute_valid", {62'h0, dout_valid}, 64'h0);
    checkOutput("misroute_resend", resend_seen, 64'd0);
    checkOutput("misroute_drop", {48'h0, drop_cnt}, 64'd0);

    $display("[TB] overflow");
    dout_ready[0] = 1'b0;
    for (int i = 0; i < 17; i++) applyStimulus(5'd3, 4'd0, 32'(i), i < 16);
    waitCycles(3);
    checkOutput("ovf_drop", {48'h0, drop_cnt}, 64'd1);
    checkOutput("ovf_resend", resend_seen, 64'd1);
    checkOutput("ovf_valid", {62'h0, dout_valid}, 64'h1);
    dout_ready[0] = 1'b1;
    waitCycles(20);
    checkOutput("ovf_drained", exp_q0.size(), 64'd0);
    checkOutput("ovf_empty", {62'h0, dout_valid}, 64'h0);

    $display("[TB] full with simultaneous pop");
    dout_ready[0] = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(5'd3, 4'd0, 32'h100 + 32'(i), 1'b1);
    waitCycles(2);
    applyStimulus(5'd3, 4'd0, 32'h200, 1'b1);
    dout_ready[0] = 1'b1;
    waitCycles(1);
    dout_ready[0] = 1'b0;
    checkOutput("fullpop_drop", {48'h0, drop_cnt}, 64'd1);
    applyStimulus(5'd3, 4'd0, 32'h201, 1'b0);
    waitCycles(3);
    checkOutput("fullpop_still_full", {48'h0, drop_cnt}, 64'd2);
    checkOutput("fullpop_resend", resend_seen, 64'd2);
    dout_ready[0] = 1'b1;
    waitCycles(20);
    checkOutput("fullpop_drained", exp_q0.size(), 64'd0);

    $display("[TB] gating and independence");
    ap_start = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(5'd3, 4'(i % 2), 32'h500 + 32'(i), 1'b0);
    waitCycles(3);
    checkOutput("gate_valid", {62'h0, dout_valid}, 64'h0);
    checkOutput("gate_misroute", {48'h0, misroute_cnt}, 64'd2);
    checkOutput("gate_drop", {48'h0, drop_cnt}, 64'd2);
    ap_start = 1'b1;
    dout_ready = 2'b10;
    rx_cnt1 = 0;
    for (int i = 0; i < 3; i++) applyStimulus(5'd3, 4'd0, 32'h300 + 32'(i), 1'b1);
    for (int i = 0; i < 100; i++) applyStimulus(5'd3, 4'd1, 32'h1000 + 32'(i), 1'b1);
    waitCycles(5);
    checkOutput("indep_rx1", rx_cnt1, 64'd100);
    checkOutput("indep_q1", exp_q1.size(), 64'd0);
    checkOutput("indep_stalled", {62'h0, dout_valid}, 64'h1);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 5; i++) applyStimulus(5'd3, 4'd0, 32'h400 + 32'(i), 1'b1);
    waitCycles(2);
    checkOutput("pre_rst_q0", exp_q0.size(), 64'd8);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checkOutput("arst_valid", {62'h0, dout_valid}, 64'h0);
    checkOutput("arst_data", dout_data, 64'h0);
    checkOutput("arst_drop", {48'h0, drop_cnt}, 64'h0);
    checkOutput("arst_misroute", {48'h0, misroute_cnt}, 64'h0);
    exp_q0.delete();
    exp_q1.delete();
    dout_ready = 2'b11;
    @(posedge clk); #3;
    reset = 1'b1;
    applyStimulus(5'd3, 4'd0, 32'hCAFE0001, 1'b1);
    checkOutput("post_rst_early", {62'h0, dout_valid}, 64'h0);
    waitCycles(1);
    checkOutput("post_rst_valid", {62'h0, dout_valid}, 64'h1);
    checkOutput("post_rst_data", {32'h0, dout_data[31:0]}, 64'hCAFE0001);
    waitCycles(3);
    checkOutput("post_rst_q0", exp_q0.size(), 64'd0);
    checkOutput("post_rst_drop", {48'h0, drop_cnt}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
